// File: rtl/code_fetch.sv
// ---------------------------------------------------------------------------
// code_fetch
//   Instruction prefetch controller. Keeps a 16-byte code window that starts
//   at the dword containing eip. The window is filled through a
//   single-outstanding, dword-aligned memory read handshake. It advances by
//   the instruction length the decoder retires. A control transfer flushes
//   the window and refills it.
//
// Ports
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   jump, jump_eip     : control transfer and its new linear address
//   consume            : decoder retires an instruction (only while valid)
//   consume_len        : retired length in bytes, 1..15 (0 = no-op)
//   codebuf            : 4-dword window, dword k in bits [32k+31:32k]
//   align              : byte offset of eip inside dword 0
//   eip                : current linear instruction address
//   valid              : all four window dwords are loaded
//   mem_address        : dword-aligned read address
//   mem_read           : read request, held until mem_ready
//   mem_ready          : read completes this cycle, mem_data is valid
//   mem_data           : read data
// ---------------------------------------------------------------------------
module code_fetch #(
  parameter logic [31:0] RESET_EIP = 32'h000FFFF0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         jump,
  input  logic [31:0]  jump_eip,
  input  logic         consume,
  input  logic [3:0]   consume_len,
  output logic [127:0] codebuf,
  output logic [1:0]   align,
  output logic [31:0]  eip,
  output logic         valid,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  input  logic         mem_ready,
  input  logic [31:0]  mem_data
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] RESET_FETCH = {RESET_EIP[31:2], 2'b00};

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      eip_nxt;
  logic [31:0]      fetch_addr;
  logic [31:0]      fetch_nxt;
  logic [2:0]       count;
  logic [2:0]       count_nxt;
  logic [3:0][31:0] win;
  logic [3:0][31:0] win_nxt;
  logic             valid_nxt;
  logic             mem_read_nxt;
  logic [31:0]      mem_address_nxt;

  logic [4:0]       span;
  logic [2:0]       drop;
  logic             take;
  logic             accept;
  logic [1:0]       slot;

  // Shift the window down by n dwords; vacated upper slots read as zero.
  function automatic logic [3:0][31:0] shift_window(input logic [3:0][31:0] w,
                                                     input logic [2:0]       n);
    logic [3:0][31:0] r;
    case (n)
      3'd0:    r = w;
      3'd1:    r = {32'd0, w[3:1]};
      3'd2:    r = {64'd0, w[3:2]};
      3'd3:    r = {96'd0, w[3]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign codebuf = win;
  assign align   = eip[1:0];

  // State register (all architectural and output registers)
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FILL;
      eip         <= RESET_EIP;
      count       <= 3'd0;
      fetch_addr  <= RESET_FETCH;
      win         <= '0;
      valid       <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= RESET_FETCH;
    end else begin
      state       <= state_nxt;
      eip         <= eip_nxt;
      count       <= count_nxt;
      fetch_addr  <= fetch_nxt;
      win         <= win_nxt;
      valid       <= valid_nxt;
      mem_read    <= mem_read_nxt;
      mem_address <= mem_address_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    eip_nxt   = eip;
    count_nxt = count;
    fetch_nxt = fetch_addr;
    win_nxt   = win;
    slot      = 2'd0;

    // Bytes from the start of dword 0 to the end of the retired instruction;
    // every whole dword crossed leaves the window.
    span   = {3'd0, align} + {1'b0, consume_len};
    drop   = span[4:2];
    take   = consume && valid && (consume_len != 4'd0);
    accept = mem_read && mem_ready;

    if (jump) begin
      eip_nxt   = jump_eip;
      count_nxt = 3'd0;
      fetch_nxt = {jump_eip[31:2], 2'b00};
      // An outstanding read must finish before a new address may be issued;
      // a read completing this very cycle is simply dropped.
      state_nxt = (mem_read && !mem_ready) ? DRAIN : FILL;
    end else if (state == DRAIN) begin
      // Wait out the stale read; its data never enters the window.
      if (mem_ready) state_nxt = FILL;
    end else begin
      if (take) begin
        eip_nxt   = eip + {28'd0, consume_len};
        count_nxt = count - drop;
        win_nxt   = shift_window(win, drop);
      end
      // The returning dword lands after any shift, at the first empty slot.
      if (accept) begin
        slot          = count_nxt[1:0];
        win_nxt[slot] = mem_data;
        count_nxt     = count_nxt + 3'd1;
        fetch_nxt     = fetch_addr + 32'd4;
      end
      state_nxt = (count_nxt == 3'd4) ? FULL : FILL;
    end
  end

  // Output logic (registered next cycle)
  always_comb begin
    valid_nxt       = (state_nxt == FULL);
    mem_read_nxt    = (state_nxt != FULL);
    // In DRAIN the pending request keeps its original address.
    mem_address_nxt = (state_nxt == DRAIN) ? mem_address : fetch_nxt;
  end

endmodule

// File: tb/tb_code_fetch.sv
// ---------------------------------------------------------------------------
// tb_code_fetch
//   Scoreboard bench for code_fetch. Stimulus pushes expected read
//   addresses, expected windows (checked when valid rises) and expected
//   state snapshots (checked at the next falling edge) into queues; one
//   monitor process pops and compares. Memory returns the address as data.
// ---------------------------------------------------------------------------
module tb_code_fetch;

  logic         clock = 1'b0;
  logic         reset;
  logic         jump;
  logic [31:0]  jump_eip;
  logic         consume;
  logic [3:0]   consume_len;
  logic [127:0] codebuf;
  logic [1:0]   align;
  logic [31:0]  eip;
  logic         valid;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_ready;
  logic [31:0]  mem_data;

  code_fetch #(.RESET_EIP(32'h000FFFF0)) dut (
    .clock       (clock),
    .reset       (reset),
    .jump        (jump),
    .jump_eip    (jump_eip),
    .consume     (consume),
    .consume_len (consume_len),
    .codebuf     (codebuf),
    .align       (align),
    .eip         (eip),
    .valid       (valid),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data)
  );

  always #5 clock = ~clock;

  assign mem_data = mem_address;

  typedef struct {
    logic [31:0]  eip;
    logic [127:0] cb;
  } win_t;

  typedef struct {
    string        name;
    bit           only_valid;
    logic [31:0]  eip;
    logic         valid;
    logic         mem_read;
    logic [31:0]  addr;
    logic [127:0] cb;
    logic [127:0] mask;
  } snap_t;

  localparam logic [127:0] ALL  = {128{1'b1}};
  localparam logic [127:0] LO96 = {32'd0, {96{1'b1}}};
  localparam logic [127:0] NONE = 128'd0;

  logic [31:0] addr_q[$];
  win_t        win_q[$];
  snap_t       snap_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;
  bit valid_prev = 1'b0;

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    logic [31:0] ea;
    win_t        w;
    snap_t       s;
    if (mem_read === 1'b1 && mem_ready === 1'b1) begin
      if (addr_q.size() == 0) begin
        cmp("unexpected_read", 128'(mem_address), 128'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        ea = addr_q.pop_front();
        cmp("read_addr", 128'(mem_address), 128'(ea));
      end
    end
    if (valid === 1'b1 && !valid_prev) begin
      if (win_q.size() == 0) begin
        cmp("unexpected_valid", 128'(eip), 128'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = win_q.pop_front();
        cmp("win.eip", 128'(eip), 128'(w.eip));
        cmp("win.codebuf", codebuf, w.cb);
      end
    end
    valid_prev = (valid === 1'b1);
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      if (s.only_valid) begin
        cmp({s.name, ".valid"}, 128'(valid), 128'(1'b1));
      end else begin
        cmp({s.name, ".eip"}, 128'(eip), 128'(s.eip));
        cmp({s.name, ".align"}, 128'(align), 128'(s.eip[1:0]));
        cmp({s.name, ".valid"}, 128'(valid), 128'(s.valid));
        cmp({s.name, ".mem_read"}, 128'(mem_read), 128'(s.mem_read));
        cmp({s.name, ".mem_address"}, 128'(mem_address), 128'(s.addr));
        if (s.mask != NONE) cmp({s.name, ".codebuf"}, codebuf & s.mask, s.cb & s.mask);
      end
    end
    if (done) begin
      cmp("addr_q_drained", 128'(addr_q.size()), 128'd0);
      cmp("win_q_drained", 128'(win_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic snap(input string name, input logic [31:0] e, input logic v,
                      input logic mr, input logic [31:0] a,
                      input logic [127:0] cb, input logic [127:0] m);
    snap_t s;
    s.name = name; s.only_valid = 1'b0; s.eip = e; s.valid = v;
    s.mem_read = mr; s.addr = a; s.cb = cb; s.mask = m;
    snap_q.push_back(s);
  endtask

  task automatic exp_win(input logic [31:0] e, input logic [127:0] cb);
    win_t w;
    w.eip = e; w.cb = cb;
    win_q.push_back(w);
  endtask

  task automatic exp_reads(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
    addr_q.push_back(a0); addr_q.push_back(a1);
    addr_q.push_back(a2); addr_q.push_back(a3);
  endtask

  task automatic wait_valid(input string name);
    snap_t s;
    for (int i = 0; i < 40; i++) begin
      if (valid === 1'b1) return;
      tick();
    end
    s.name = {name, "_timeout"}; s.only_valid = 1'b1; s.eip = '0; s.valid = 1'b1;
    s.mem_read = 1'b0; s.addr = '0; s.cb = '0; s.mask = '0;
    snap_q.push_back(s);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; jump = 1'b0; jump_eip = '0;
    consume = 1'b0; consume_len = 4'd0; mem_ready = 1'b1;
    tick(); tick();
    snap("reset", 32'h000FFFF0, 1'b0, 1'b0, 32'h000FFFF0, NONE, ALL);

    // Reset fill with zero-wait memory
    exp_reads(32'h000FFFF0, 32'h000FFFF4, 32'h000FFFF8, 32'h000FFFFC);
    exp_win(32'h000FFFF0, {32'h000FFFFC, 32'h000FFFF8, 32'h000FFFF4, 32'h000FFFF0});
    reset = 1'b0;
    wait_valid("fill0");
    snap("full0", 32'h000FFFF0, 1'b1, 1'b0, 32'h00100000,
         {32'h000FFFFC, 32'h000FFFF8, 32'h000FFFF4, 32'h000FFFF0}, ALL);

    // Partial consume: len 6 from align 0 drops one dword
    addr_q.push_back(32'h00100000);
    consume = 1'b1; consume_len = 4'd6;
    tick();
    consume = 1'b0;
    snap("consume6", 32'h000FFFF6, 1'b0, 1'b1, 32'h00100000,
         {32'd0, 32'h000FFFFC, 32'h000FFFF8, 32'h000FFFF4}, LO96);
    exp_win(32'h000FFFF6, {32'h00100000, 32'h000FFFFC, 32'h000FFFF8, 32'h000FFFF4});
    wait_valid("refill6");

    // Consume 1: reach align 3 without dropping a dword
    consume = 1'b1; consume_len = 4'd1;
    tick();
    consume = 1'b0;
    snap("consume1", 32'h000FFFF7, 1'b1, 1'b0, 32'h00100004,
         {32'h00100000, 32'h000FFFFC, 32'h000FFFF8, 32'h000FFFF4}, ALL);

    // Max drop: align 3 + 15 = 18, all four dwords leave
    exp_reads(32'h00100004, 32'h00100008, 32'h0010000C, 32'h00100010);
    consume = 1'b1; consume_len = 4'd15;
    tick();
    consume = 1'b0;
    snap("maxdrop", 32'h00100006, 1'b0, 1'b1, 32'h00100004, NONE, NONE);
    exp_win(32'h00100006, {32'h00100010, 32'h0010000C, 32'h00100008, 32'h00100004});
    wait_valid("refill_max");

    // Ignored inputs: zero length while full, then any consume while not valid
    mem_ready = 1'b0;
    consume = 1'b1; consume_len = 4'd0;
    tick();
    snap("len0", 32'h00100006, 1'b1, 1'b0, 32'h00100014,
         {32'h00100010, 32'h0010000C, 32'h00100008, 32'h00100004}, ALL);
    consume_len = 4'd4;
    tick();
    snap("consume4", 32'h0010000A, 1'b0, 1'b1, 32'h00100014,
         {32'd0, 32'h00100010, 32'h0010000C, 32'h00100008}, LO96);
    consume_len = 4'd5;
    tick();
    snap("consume_invalid", 32'h0010000A, 1'b0, 1'b1, 32'h00100014, NONE, NONE);
    consume = 1'b0;
    addr_q.push_back(32'h00100014);
    exp_win(32'h0010000A, {32'h00100014, 32'h00100010, 32'h0010000C, 32'h00100008});
    mem_ready = 1'b1;
    wait_valid("refill4");

    // Jump during a stalled request, including a retarget while draining
    reset = 1'b1;
    tick();
    snap("reset_full", 32'h000FFFF0, 1'b0, 1'b0, 32'h000FFFF0, NONE, ALL);
    addr_q.push_back(32'h000FFFF0);
    reset = 1'b0;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    jump = 1'b1; jump_eip = 32'h00000777;
    tick();
    snap("drain_jump1", 32'h00000777, 1'b0, 1'b1, 32'h000FFFF4, NONE, NONE);
    jump_eip = 32'h00012345;
    tick();
    jump = 1'b0;
    snap("drain_jump2", 32'h00012345, 1'b0, 1'b1, 32'h000FFFF4, NONE, NONE);
    tick();
    snap("drain_hold", 32'h00012345, 1'b0, 1'b1, 32'h000FFFF4, NONE, NONE);
    addr_q.push_back(32'h000FFFF4);
    exp_reads(32'h00012344, 32'h00012348, 32'h0001234C, 32'h00012350);
    exp_win(32'h00012345, {32'h00012350, 32'h0001234C, 32'h00012348, 32'h00012344});
    mem_ready = 1'b1;
    wait_valid("fill_jump");

    // Jump in the same cycle as a completing read: no drain
    addr_q.push_back(32'h00012354);
    consume = 1'b1; consume_len = 4'd3;
    tick();
    consume = 1'b0;
    jump = 1'b1; jump_eip = 32'h000ABCDE;
    tick();
    jump = 1'b0;
    snap("jump_ready", 32'h000ABCDE, 1'b0, 1'b1, 32'h000ABCDC, NONE, NONE);
    exp_reads(32'h000ABCDC, 32'h000ABCE0, 32'h000ABCE4, 32'h000ABCE8);
    exp_win(32'h000ABCDE, {32'h000ABCE8, 32'h000ABCE4, 32'h000ABCE0, 32'h000ABCDC});
    wait_valid("fill_jr");

    // Address wrap-around at 2^32
    exp_reads(32'hFFFFFFFC, 32'h00000000, 32'h00000004, 32'h00000008);
    jump = 1'b1; jump_eip = 32'hFFFFFFFE;
    tick();
    jump = 1'b0;
    snap("jump_wrap", 32'hFFFFFFFE, 1'b0, 1'b1, 32'hFFFFFFFC, NONE, NONE);
    exp_win(32'hFFFFFFFE, {32'h00000008, 32'h00000004, 32'h00000000, 32'hFFFFFFFC});
    wait_valid("fill_wrap");
    exp_reads(32'h0000000C, 32'h00000010, 32'h00000014, 32'h00000018);
    consume = 1'b1; consume_len = 4'd15;
    tick();
    consume = 1'b0;
    snap("consume_wrap", 32'h0000000D, 1'b0, 1'b1, 32'h0000000C, NONE, NONE);
    exp_win(32'h0000000D, {32'h00000018, 32'h00000014, 32'h00000010, 32'h0000000C});
    wait_valid("refill_wrap");

    // Reset in the middle of a fill
    addr_q.push_back(32'h00000500);
    addr_q.push_back(32'h00000504);
    jump = 1'b1; jump_eip = 32'h00000500;
    tick();
    jump = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    snap("reset_midfill", 32'h000FFFF0, 1'b0, 1'b0, 32'h000FFFF0, NONE, ALL);
    reset = 1'b0;
    exp_reads(32'h000FFFF0, 32'h000FFFF4, 32'h000FFFF8, 32'h000FFFFC);
    exp_win(32'h000FFFF0, {32'h000FFFFC, 32'h000FFFF8, 32'h000FFFF4, 32'h000FFFF0});
    wait_valid("fill_after_reset");
    tick();
    done = 1'b1;
  end

endmodule

// File: doc/code_fetch.md
# code_fetch

Instruction prefetch controller that sequences the decoder's code window. It fetches dword-aligned code from memory through a single-outstanding read handshake and keeps a 16-byte window starting at the dword containing `eip`. The window is presented to the decoder as `codebuf` plus a 2-bit `align`. It advances the window by the instruction length the decoder reports, and flushes and refills on control transfers.

## Interface
- `RESET_EIP`, default 32'h000FFFF0: linear fetch address loaded at reset.

- `clock`  in  1: sole clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `jump`  in  1: control transfer; flush the window and restart at `jump_eip`.
- `jump_eip`  in  32: new linear instruction address.
- `consume`  in  1: decoder retires an instruction; honoured only while `valid`=1.
- `consume_len`  in  4: instruction length in bytes, 1..15; 0 is ignored.
- `codebuf`  out  128: window, dword k in bits [32k+31:32k], little-endian bytes.
- `align`  out  2: byte offset of `eip` inside dword 0, equal to `eip[1:0]`.
- `eip`  out  32: current linear instruction address.
- `valid`  out  1: all 4 window dwords are loaded.
- `mem_address`  out  32: dword-aligned read address, bits [1:0]=0.
- `mem_read`  out  1: read request.
- `mem_ready`  in  1: read completes this cycle; `mem_data` is valid.
- `mem_data`  in  32: read data.

## Operation
- **State:** `eip`, `count` (dwords loaded, 0..4), `fetch_addr`, 4×32 window, FSM {FILL, FULL, DRAIN}.
- **Invariant outside DRAIN:** `fetch_addr` = (`eip` & ~3) + 4·`count`. `mem_address` = `fetch_addr`.
- **FILL:**
  - `mem_read`=1.
  - On `mem_ready`, `mem_data` is written to window slot `count`, and `count` and `fetch_addr` increment (by 1 and by 4).
  - Go to FULL when `count` reaches 4.
- **FULL:**
  - `mem_read`=0 and `valid`=1.
  - Go to FILL when a consume drops at least one dword.
- **DRAIN:**
  - Entered on `jump` while a request is pending and `mem_ready`=0.
  - `mem_read` stays 1 and `mem_address` keeps its old value until `mem_ready`.
  - The returned data is discarded. Then go to FILL with the new `fetch_addr`.
- **Consume** (`consume`=1, `valid`=1, `consume_len`≠0):
  - s = `align` + `consume_len` (5-bit, max 18).
  - drop = s>>2 (0..4). The new `align` = s[1:0] and `eip` += `consume_len`.
  - The window shifts down by drop dwords and `count` -= drop.
- **Consume and `mem_ready` in the same cycle:** the shift is applied first. The returning dword is written to slot (`count` − drop), and `count` ends at `count` − drop + 1.
  - This case arises only if `count`=4 was reached that cycle. In that case `valid` was still 0, so the consume is ignored.
  - In practice a consume and a return never combine. The rule is stated for completeness.
- **Jump (highest priority; overrides `consume`):**
  - `eip` ← `jump_eip`, `count` ← 0, `fetch_addr` ← `jump_eip` & ~3, `valid` ← 0.
  - Next state:
    - FILL if no request is pending, or if `mem_ready`=1 this cycle (that data is discarded).
    - DRAIN if a request is pending and `mem_ready`=0.
  - A `jump` while in DRAIN updates the target and stays in DRAIN.
- **Consume while `valid`=0:** ignored and nothing changes.
- **Reset values:**
  - `eip`=`RESET_EIP` and `align`=`RESET_EIP[1:0]`.
  - `codebuf`=0, `valid`=0, `count`=0.
  - `mem_read`=0 and `mem_address`=`RESET_EIP` & ~3.
  - State = FILL.
  - Reset mid-request drops `mem_read` immediately. The memory side must abandon the transfer.

## Timing
- All outputs are registered.
- **Request rule:** `mem_read` and `mem_address` are stable from assertion until the cycle `mem_ready`=1 is sampled.
- **Back-to-back fetch:** the next request is presented in the following cycle with `mem_read` held high, so full throughput is 1 dword/cycle.
- **First request:** asserted in the first cycle after `reset` deasserts.
- **Fill latency:** `valid` rises in the cycle after the 4th accepted dword. With zero-wait memory that is 5 cycles after reset or jump.
- **Consume:** takes effect at the clock edge where `consume` is sampled. If drop≥1, `valid` falls in the next cycle and refill starts in that same cycle.
- **Jump:** `valid` is 0 in the cycle after the edge where `jump` is sampled. `eip` and `align` show the new target in the same cycle.
- **Wrap-around:** `eip` and `fetch_addr` wrap modulo 2^32. No special handling.

## Test plan
- **Reset fill:** `RESET_EIP`=FFFF0, memory returns the address as data with `mem_ready` tied high. Required: addresses FFFF0, FFFF4, FFFF8, FFFFC. Then `valid`=1, `codebuf`={000FFFFC,000FFFF8,000FFFF4,000FFFF0}, `align`=0, `mem_read`=0.
- **Partial consume:** from full, consume `consume_len`=6. Required:
  - `eip`=FFFF6, `align`=2, drop 1.
  - `codebuf`[95:0]={000FFFFC,000FFFF8,000FFFF4}.
  - Next request to 00100000, after which `valid`=1 again.
- **Max drop:** with `align`=3, consume 15. Required: s=18, drop 4, `count`=0, `align`=2, `eip` +15, refill of 4 dwords.
- **Jump during wait:** `jump_eip`=12345 while a request to FFFF4 is pending with `mem_ready` low for 3 cycles. Required:
  - `mem_address` stays FFFF4 until ready, and that data is discarded.
  - Next requests go to 12344, 12348, and onward; final `align`=1.
- **Jump with same-cycle ready:** `jump` and `mem_ready` in one cycle. Required: data discarded and the next-cycle request goes to `jump_eip` & ~3 with no DRAIN.
- **Ignored inputs:** consume while `valid`=0, and consume with `consume_len`=0. Required: no change to `eip` or `count`. Reset asserted mid-fill gives `mem_read`=0 and `valid`=0 in the next cycle.
